// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg
// Shared types and helpers for the FIFO drain-side reader.
//   state_t : controller states (IDLE, WAIT, SEND)
//   beat_w  : width of the beat counter for a given word/beat ratio,
//             never less than one bit so the counter always exists.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    function automatic int beat_w(input int par_read, input int par_out);
        int beats;
        beats = par_read / par_out;
        if (beats <= 2) begin
            return 1;
        end
        return $clog2(beats);
    endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// fifo_reader_if
// Bundles the FIFO read port and the downstream valid/ready stream that
// fifo_reader sits between.
//   master : the reader's view (drives fifo_ren and the output stream)
//   slave  : the environment's view (FIFO flags/data and out_ready)
// Signals:
//   fifo_empty, fifo_dout, fifo_ren          FIFO read side
//   out_data, out_valid, out_ready, out_last downstream stream
interface fifo_reader_if #(
    parameter int SIZE     = 16,
    parameter int PAR_READ = 4,
    parameter int PAR_OUT  = 1
);

    logic                       fifo_empty;
    logic [SIZE*PAR_READ-1:0]   fifo_dout;
    logic                       fifo_ren;
    logic [SIZE*PAR_OUT-1:0]    out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;

    modport master (
        input  fifo_empty, fifo_dout, out_ready,
        output fifo_ren, out_data, out_valid, out_last
    );

    modport slave (
        output fifo_empty, fifo_dout, out_ready,
        input  fifo_ren, out_data, out_valid, out_last
    );

endinterface

// File: rtl/word_serializer.sv
// word_serializer
// Holds one FIFO word and walks through it PAR_OUT elements at a time,
// lowest element first.
// Ports:
//   clk        rising-edge clock
//   flush      synchronous drop of buffer and beat position
//   load       capture load_data and restart at beat 0 (wins over advance)
//   load_data  full FIFO word
//   advance    step to the next beat (wraps after the last beat)
//   data       current beat slice
//   last       current beat is the final one of the word
module word_serializer
    import fifo_reader_pkg::*;
#(
    parameter int SIZE     = 16,
    parameter int PAR_READ = 4,
    parameter int PAR_OUT  = 1
) (
    input  logic                     clk,
    input  logic                     flush,
    input  logic                     load,
    input  logic [SIZE*PAR_READ-1:0] load_data,
    input  logic                     advance,
    output logic [SIZE*PAR_OUT-1:0]  data,
    output logic                     last
);

    localparam int BEATS = PAR_READ / PAR_OUT;
    localparam int BW    = beat_w(PAR_READ, PAR_OUT);
    localparam int SLICE = SIZE * PAR_OUT;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic [SIZE*PAR_READ-1:0] buffer;
    logic [BW-1:0]            beat;

    // A load restarts the word even if a handshake lands in the same cycle,
    // which is what lets back-to-back words run without a bubble.
    always_ff @(posedge clk) begin
        if (flush) begin
            buffer <= '0;
            beat   <= '0;
        end else if (load) begin
            buffer <= load_data;
            beat   <= '0;
        end else if (advance) begin
            beat <= last ? '0 : beat + 1'b1;
        end
    end

    always_comb begin
        data = buffer[int'(beat)*SLICE +: SLICE];
        last = (beat == LAST_BEAT);
    end

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader
// Drain-side controller: pops PAR_READ-element words from a FIFO and
// streams them out PAR_OUT elements per beat over valid/ready.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset (also zeroes words_done)
//   clear       synchronous flush, keeps words_done
//   bus         fifo_reader_if.master (FIFO read port + output stream)
//   busy        controller active or a word is pending
//   words_done  wrapping count of fully sent words
// Build option:
//   FIFO_READER_PREFETCH_EN  adds a pending-word register so the next word
//                            is fetched during SEND and words go out with
//                            no idle cycles between them.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int SIZE     = 16,
    parameter int PAR_READ = 4,
    parameter int PAR_OUT  = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    fifo_reader_if.master    bus,
    output logic             busy,
    output logic [CNT_W-1:0] words_done
);

    state_t                   state;
    state_t                   next_state;
    logic                     flush;
    logic                     load;
    logic                     advance;
    logic                     count_word;
    logic [SIZE*PAR_READ-1:0] load_data;
    logic [SIZE*PAR_OUT-1:0]  ser_data;
    logic                     ser_last;

    assign flush = rst | clear;

    word_serializer #(
        .SIZE     (SIZE),
        .PAR_READ (PAR_READ),
        .PAR_OUT  (PAR_OUT)
    ) u_serializer (
        .clk       (clk),
        .flush     (flush),
        .load      (load),
        .load_data (load_data),
        .advance   (advance),
        .data      (ser_data),
        .last      (ser_last)
    );

`ifdef FIFO_READER_PREFETCH_EN
    logic                     inflight;
    logic                     pend_full;
    logic                     pend_load;
    logic                     pend_take;
    logic [SIZE*PAR_READ-1:0] pend_data;

    // inflight marks a pop issued during SEND whose data shows up this cycle.
    // Unless the FSM consumes it directly, that data parks in the pending
    // register. A pop needs both to be clear, so they are never set together.
    always_ff @(posedge clk) begin
        if (flush) begin
            inflight  <= 1'b0;
            pend_full <= 1'b0;
            pend_data <= '0;
        end else begin
            inflight <= bus.fifo_ren && (state == SEND);
            if (pend_load) begin
                pend_full <= 1'b1;
                pend_data <= bus.fifo_dout;
            end else if (pend_take) begin
                pend_full <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE) || pend_full || inflight;
`else
    assign busy = (state != IDLE);
`endif

    always_ff @(posedge clk) begin
        if (flush) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, FIFO pop and serializer control. A flush overrides
    // everything at the end so no pop or load happens in a reset/clear cycle.
    always_comb begin
        next_state    = state;
        bus.fifo_ren  = 1'b0;
        bus.out_valid = 1'b0;
        load          = 1'b0;
        load_data     = bus.fifo_dout;
        advance       = 1'b0;
        count_word    = 1'b0;
`ifdef FIFO_READER_PREFETCH_EN
        pend_load     = inflight;
        pend_take     = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef FIFO_READER_PREFETCH_EN
                // A pop issued on the final handshake lands here; use it
                // before asking the FIFO for anything new.
                if (pend_full) begin
                    load       = 1'b1;
                    load_data  = pend_data;
                    pend_take  = 1'b1;
                    next_state = SEND;
                end else if (inflight) begin
                    load       = 1'b1;
                    pend_load  = 1'b0;
                    next_state = SEND;
                end else
`endif
                begin
                    bus.fifo_ren = !bus.fifo_empty;
                    if (!bus.fifo_empty) begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                load       = 1'b1;
                next_state = SEND;
            end
            SEND: begin
                bus.out_valid = 1'b1;
                advance       = bus.out_ready;
`ifdef FIFO_READER_PREFETCH_EN
                bus.fifo_ren  = !bus.fifo_empty && !pend_full && !inflight;
`endif
                if (bus.out_ready && ser_last) begin
                    count_word = 1'b1;
`ifdef FIFO_READER_PREFETCH_EN
                    if (pend_full) begin
                        load      = 1'b1;
                        load_data = pend_data;
                        pend_take = 1'b1;
                    end else if (inflight) begin
                        load      = 1'b1;
                        pend_load = 1'b0;
                    end else begin
                        next_state = IDLE;
                    end
`else
                    next_state = IDLE;
`endif
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (flush) begin
            next_state   = IDLE;
            bus.fifo_ren = 1'b0;
            load         = 1'b0;
            advance      = 1'b0;
            count_word   = 1'b0;
`ifdef FIFO_READER_PREFETCH_EN
            pend_load    = 1'b0;
            pend_take    = 1'b0;
`endif
        end
    end

    // Data and last are forced low outside SEND so the idle stream is quiet.
    assign bus.out_data = bus.out_valid ? ser_data : '0;
    assign bus.out_last = bus.out_valid && ser_last;

    // clear leaves the count alone; only rst zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            words_done <= '0;
        end else if (count_word) begin
            words_done <= words_done + 1'b1;
        end
    end

endmodule
